tile_unloader: RTL and testbench
================================

// Module: tile_unloader
// PURPOSE
//  Parallel-in / byte-serial-out unloader; the inverse of the byte-write, full-parallel-read tile RAM.
//  Captures one flattened tile (ROWS*COLS*CH bytes) in a single cycle.
//  Streams the tile out one byte per handshake, with its linear index.
//  Each byte plus index can be written back into a tile RAM (waddr=dout_addr, din=dout),
//  or sent to the host/output path. Sits after the PE array / result RAM.
// PARAMETERS
//  ROWS  8                  tile rows
//  COLS  8                  tile columns
//  CH    1                  channels per tile element
//  DW    8                  bits per element
//  N     ROWS*COLS*CH       elements per tile (derived, do not override)
//  AW    $clog2(N)          index width (derived)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  load        in   1      capture din and start a stream (honoured only in IDLE)
//  din         in   N*DW   flattened tile; element i = din[i*DW +: DW]
//  busy        out  1      1 while a stream is in progress (STREAM state)
//  dout_valid  out  1      current byte valid
//  dout_ready  in   1      sink accepts byte when dout_valid & dout_ready
//  dout        out  DW     current element; 0 when dout_valid=0
//  dout_addr   out  AW     index of current element; 0 when dout_valid=0
//  dout_last   out  1      dout_valid & (dout_addr==N-1)
//  done        out  1      one-cycle pulse after the last byte is accepted
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - state=IDLE, idx=0; busy, dout_valid, dout_last, done all 0.
//   - Capture register is not reset.
//  FSM: IDLE, STREAM
//   - IDLE, load=1: shadow<=din, idx<=0, ->STREAM. din is sampled only in this cycle.
//   - STREAM: dout_valid=1, dout=shadow[idx], dout_addr=idx.
//     On handshake: if idx==N-1 -> IDLE, idx<=0, done<=1 (next cycle); else idx<=idx+1.
//   - No handshake: hold idx and dout stable. dout_valid never drops without a handshake.
//  Timing
//   - load sampled at edge t -> first byte (addr 0) valid in cycle t+1.
//   - dout_ready held 1: one byte/cycle; last accepted in cycle t+N; done=1 in cycle t+N+1.
//   - Earliest next load is accepted in cycle t+N+1.
//  Boundary rules
//   - load while busy (including the final-handshake cycle): ignored, shadow unchanged.
//   - load in the cycle done=1: accepted (state is IDLE).
//   - dout_ready=1 with dout_valid=0: no effect.
//   - rst mid-stream: abort. Next cycle is IDLE, valid=0, no done pulse; stream is not resumed.
//   - idx never exceeds N-1. Wrap occurs only via the last-byte transition.
//   - N not a power of 2: addresses N..2^AW-1 are never driven.
//  Outputs busy, dout_valid, done, idx/state are registered.
//  dout, dout_addr, dout_last are combinational from registers only; no input-to-output path.
// STRUCTURE
//  Shared package / include (tile_pkg.vh)
//   - TILE_ROWS, TILE_COLS, TILE_CH, TILE_DW, TILE_N, TILE_AW.
//   - FSM encodings ST_IDLE=1'b0, ST_STREAM=1'b1. Shared with the tile RAM so packing matches.
//  Sub-module: tile_byte_mux
//   - Combinational N:1 DW-wide selector: sel[AW], bus[N*DW] -> byte.
//   - Reused by other tile readers.
//  Top: shadow register + idx counter + FSM + output gating.
// TESTING
//  - Basic stream: din element i = i, load 1 cycle, ready=1 -> addrs 0..63, bytes 0x00..0x3F on
//    consecutive cycles; last at addr 63; done exactly one cycle after.
//  - Backpressure: ready toggles 1,0,0,1... with random stalls -> every byte appears once, in order;
//    dout/dout_addr stable while stalled; total handshakes=64.
//  - Load while busy: load again with din=all 0xFF at addr 10 -> ignored, stream completes with
//    the original data; done pulses once.
//  - Back-to-back: load tile A, then load tile B in the done cycle -> B addr 0 valid next cycle,
//    no gap beyond 1 cycle, no mixing of A and B.
//  - Reset mid-stream: rst at addr 20 -> next cycle valid=0, busy=0, done=0; new load restarts at addr 0.
//  - Round trip: stream into the tile RAM (waddr=dout_addr, wen=handshake) -> RAM parallel dout == din.

Source files
------------

// File: rtl/tile_unloader_pkg.sv
// Shared tile geometry and FSM encodings for the tile unloader and its companion tile RAM.
// Keeping them in one place guarantees both sides agree on byte packing order.
package tile_unloader_pkg;

  localparam int TILE_ROWS = 8;
  localparam int TILE_COLS = 8;
  localparam int TILE_CH   = 1;
  localparam int TILE_DW   = 8;
  localparam int TILE_N    = TILE_ROWS * TILE_COLS * TILE_CH;
  localparam int TILE_AW   = (TILE_N > 1) ? $clog2(TILE_N) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/tile_byte_mux.sv
// Combinational N:1 element selector over a flattened tile bus.
// Unmatched select values (only possible when N is not a power of two) yield zero.
module tile_byte_mux #(
  parameter int N  = 64,
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic [AW-1:0]   sel,
  input  logic [N*DW-1:0] bus,
  output logic [DW-1:0]   data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == AW'(i)) data = bus[i*DW +: DW];
    end
  end

endmodule

// File: rtl/tile_unloader.sv
// Parallel-in, element-serial-out tile unloader: captures a whole tile in one cycle,
// then streams it element by element with its linear index over a valid/ready handshake.
module tile_unloader
  import tile_unloader_pkg::*;
#(
  parameter  int ROWS = TILE_ROWS,
  parameter  int COLS = TILE_COLS,
  parameter  int CH   = TILE_CH,
  parameter  int DW   = TILE_DW,
  localparam int N    = ROWS * COLS * CH,
  localparam int AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [N*DW-1:0] din,
  output logic            busy,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [DW-1:0]   dout,
  output logic [AW-1:0]   dout_addr,
  output logic            dout_last,
  output logic            done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic [0:0]      state;
  logic [AW-1:0]   idx;
  logic [N*DW-1:0] shadow;
  logic [DW-1:0]   sel_byte;
  logic            accept;
  logic            streaming;

  assign streaming = (state == ST_STREAM);
  assign accept    = streaming && dout_ready;

  // Shadow register is deliberately left unreset; it only matters once a load has been taken.
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_IDLE) && load) shadow <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            idx   <= '0;
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  tile_byte_mux #(
    .N  (N),
    .DW (DW),
    .AW (AW)
  ) u_mux (
    .sel  (idx),
    .bus  (shadow),
    .data (sel_byte)
  );

  // Outputs are zeroed whenever nothing valid is presented so a downstream RAM never sees stale data.
  assign busy       = streaming;
  assign dout_valid = streaming;
  assign dout       = streaming ? sel_byte : '0;
  assign dout_addr  = streaming ? idx : '0;
  assign dout_last  = streaming && (idx == LAST_IDX);

endmodule

// File: tb/tb_tile_unloader.sv
// Scoreboard bench for tile_unloader: a tile-level model predicts accepted loads and queues
// the expected element stream, while a separate monitor checks the DUT every cycle.
module tb_tile_unloader;
  import tile_unloader_pkg::*;

  localparam int N  = TILE_N;
  localparam int DW = TILE_DW;
  localparam int AW = TILE_AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [N*DW-1:0] din;
  logic            busy;
  logic            dout_valid;
  logic            dout_ready;
  logic [DW-1:0]   dout;
  logic [AW-1:0]   dout_addr;
  logic            dout_last;
  logic            done;

  int checks   = 0;
  int failures = 0;

  item_t exp_q[$];
  bit    m_busy = 1'b0;
  bit    m_done = 1'b0;
  int    m_left = 0;
  bit    checking = 1'b0;
  int    handshakes = 0;
  int    done_count = 0;
  logic [DW-1:0] ram [N];

  tile_unloader dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tile-level reference: an accepted load enqueues the whole tile, N handshakes finish it.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (dout_ready) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (load) begin
        for (int i = 0; i < N; i++) exp_q.push_back(item_t'{addr: AW'(i), data: din[i*DW +: DW]});
        m_busy = 1'b1;
        m_left = N;
      end
    end
  end

  // Monitor samples on the falling edge, when outputs and next-edge inputs are both settled.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      check_output("busy", 64'(busy), 64'(m_busy));
      check_output("dout_valid", 64'(dout_valid), 64'(m_busy));
      check_output("done", 64'(done), 64'(m_done));
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check_output("queue_empty", 64'(exp_q.size()), 64'd1);
        end else begin
          check_output("dout_addr", 64'(dout_addr), 64'(exp_q[0].addr));
          check_output("dout", 64'(dout), 64'(exp_q[0].data));
          check_output("dout_last", 64'(dout_last), 64'(exp_q[0].addr == AW'(N - 1)));
          if (dout_ready) begin
            ram[dout_addr] = dout;
            void'(exp_q.pop_front());
            handshakes++;
          end
        end
      end else begin
        check_output("idle_dout", 64'(dout), 64'd0);
        check_output("idle_addr", 64'(dout_addr), 64'd0);
        check_output("idle_last", 64'(dout_last), 64'd0);
      end
      if (done) done_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic random_tile();
    for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'($urandom());
  endtask

  task automatic apply_stimulus(input bit ready_val);
    load = 1'b1;
    dout_ready = ready_val;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit random_ready);
    int n;
    n = 0;
    while ((m_busy || m_done) && n < budget) begin
      if (random_ready) dout_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (m_busy) check_output("timeout", 64'd1, 64'd0);
    dout_ready = 1'b1;
  endtask

  task automatic wait_handshakes(input int target, input int budget);
    int n;
    n = 0;
    while (handshakes < target && n < budget) begin
      tick();
      n++;
    end
    if (handshakes < target) check_output("hs_timeout", 64'(handshakes), 64'(target));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs0, dc0;
    logic [N*DW-1:0] tile_a;

    rst = 1'b1;
    load = 1'b0;
    dout_ready = 1'b0;
    din = '0;
    repeat (3) tick();
    rst = 1'b0;
    checking = 1'b1;
    tick();

    $display("[TB] basic stream with ramp data");
    for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'(i);
    tile_a = din;
    hs0 = handshakes;
    dc0 = done_count;
    apply_stimulus(1'b1);
    din = '0;
    wait_idle(200, 1'b0);
    tick();
    check_output("basic_handshakes", 64'(handshakes - hs0), 64'(N));
    check_output("basic_done_count", 64'(done_count - dc0), 64'd1);
    for (int i = 0; i < N; i++) check_output("roundtrip", 64'(ram[i]), 64'(tile_a[i*DW +: DW]));

    $display("[TB] backpressure");
    random_tile();
    hs0 = handshakes;
    apply_stimulus(1'b0);
    wait_idle(2000, 1'b1);
    tick();
    check_output("bp_handshakes", 64'(handshakes - hs0), 64'(N));

    $display("[TB] load while busy");
    random_tile();
    hs0 = handshakes;
    dc0 = done_count;
    apply_stimulus(1'b1);
    wait_handshakes(hs0 + 10, 200);
    din = '1;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle(200, 1'b0);
    tick();
    check_output("busy_load_done_count", 64'(done_count - dc0), 64'd1);

    $display("[TB] back-to-back loads");
    random_tile();
    apply_stimulus(1'b1);
    while (m_busy) tick();
    random_tile();
    hs0 = handshakes;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle(200, 1'b0);
    tick();
    check_output("b2b_handshakes", 64'(handshakes - hs0), 64'(N));

    $display("[TB] reset mid-stream");
    random_tile();
    hs0 = handshakes;
    apply_stimulus(1'b1);
    wait_handshakes(hs0 + 20, 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    random_tile();
    hs0 = handshakes;
    apply_stimulus(1'b1);
    wait_idle(200, 1'b0);
    tick();
    check_output("post_reset_handshakes", 64'(handshakes - hs0), 64'(N));

    $display("[TB] random loads and stalls");
    for (int c = 0; c < 600; c++) begin
      load = ($urandom_range(0, 7) == 0);
      dout_ready = 1'($urandom_range(0, 1));
      random_tile();
      tick();
    end
    load = 1'b0;
    wait_idle(2000, 1'b1);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
